mode_counter: RTL and testbench

Parametrised, multi-mode successor to the basic free-running enable counter. It supports up/down counting, a programmable terminal value, synchronous load, and three boundary policies: wrap, saturate and one-shot. It also produces a terminal-count pulse and a sticky done flag. It is the general-purpose counter for timers, dividers and sequencing logic in the design.

---
 rtl/mode_counter.sv | 85 ++++++++
 tb/tb_mode_counter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mode_counter.sv
// Multi-mode up/down counter with a programmable terminal value, synchronous load,
// wrap / saturate / one-shot boundary handling, a terminal-count pulse and a sticky done flag.
module mode_counter #(
    parameter int          WIDTH   = 8,
    parameter int unsigned MAX_VAL = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        M_WRAP    = 2'b00,
        M_SAT     = 2'b01,
        M_ONESHOT = 2'b10,
        M_RSVD    = 2'b11
    } mode_e;

    typedef struct packed {
        logic [WIDTH-1:0] count;
        logic             tc;
        logic             done;
    } cnt_state_t;

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

    cnt_state_t       cur, nxt;
    logic             at_bound;
    logic [WIDTH-1:0] load_clamped;
    mode_e            mode_q;

    assign mode_q       = mode_e'(mode);
    assign load_clamped = (load_value > MAXV) ? MAXV : load_value;

    // Boundary is judged against the direction sampled on this edge, so a
    // direction flip at MAX_VAL or 0 is an ordinary step, not a boundary event.
    assign at_bound = dir ? (cur.count == MAXV) : (cur.count == '0);

    always_comb begin
        nxt      = cur;
        nxt.tc   = 1'b0;
        if (load) begin
            nxt.count = load_clamped;
            nxt.done  = 1'b0;
        end else if (enable && !cur.done) begin
            if (!at_bound) begin
                nxt.count = dir ? cur.count + WIDTH'(1) : cur.count - WIDTH'(1);
            end else begin
                case (mode_q)
                    M_SAT: begin
                        nxt.tc = 1'b1;
                    end
                    M_ONESHOT: begin
                        nxt.tc   = 1'b1;
                        nxt.done = 1'b1;
                    end
                    default: begin
                        nxt.count = dir ? '0 : MAXV;
                        nxt.tc    = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur <= '0;
        end else begin
            cur <= nxt;
        end
    end

    assign count = cur.count;
    assign tc    = cur.tc;
    assign done  = cur.done;

endmodule

// File: tb/tb_mode_counter.sv
// Bench for mode_counter at WIDTH=3, MAX_VAL=5: vector table plus model-driven runs,
// expected results queued at drive time and checked one cycle later.
module tb_mode_counter;

    localparam int W  = 3;
    localparam int MV = 5;

    logic         clk = 1'b0;
    logic         rst, enable, load, dir;
    logic [W-1:0] load_value, count;
    logic [1:0]   mode;
    logic         tc, done;

    always #5 clk = ~clk;

    mode_counter #(.WIDTH(W), .MAX_VAL(MV)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .load_value(load_value),
        .dir(dir), .mode(mode), .count(count), .tc(tc), .done(done)
    );

    typedef struct {
        logic         r, l;
        logic [W-1:0] lv;
        logic         e, d;
        logic [1:0]   m;
        logic [W-1:0] c;
        logic         t, dn;
    } vec_t;

    typedef struct {
        logic [W-1:0] c;
        logic         t, dn;
        string        name;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(input logic r, l, input int lv, input logic e, d,
                                input logic [1:0] m, input int c, input logic t, dn);
        vec_t v;
        v.r = r; v.l = l; v.lv = W'(lv); v.e = e; v.d = d; v.m = m;
        v.c = W'(c); v.t = t; v.dn = dn;
        tbl.push_back(v);
    endfunction

    task automatic check();
        exp_t x;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        x = sb.pop_front();
        if (count !== x.c || tc !== x.t || done !== x.dn) begin
            bad++;
            $display("FAIL %s: got count=%0d tc=%b done=%b, want count=%0d tc=%b done=%b",
                     x.name, count, tc, done, x.c, x.t, x.dn);
        end
    endtask

    task automatic drive(input logic r, l, input logic [W-1:0] lv, input logic e, d,
                         input logic [1:0] m, input logic [W-1:0] ec, input logic et, ed,
                         input string nm);
        exp_t x;
        @(negedge clk);
        rst = r; load = l; load_value = lv; enable = e; dir = d; mode = m;
        x.c = ec; x.t = et; x.dn = ed; x.name = nm;
        sb.push_back(x);
        @(posedge clk);
        #1;
        check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0; dir = 1'b1; mode = 2'b00;

        // rst ld lv en dir mode -> count tc done
        add(1,0,0,0,1,2'b00, 0,0,0);                       // reset state
        for (int i = 0; i < 7; i++) add(0,0,0,1,1,2'b00, (i+1)%6, (i == 5), 0);
        add(1,0,0,0,0,2'b00, 0,0,0);
        add(0,0,0,1,0,2'b00, 5,1,0);                       // down wrap 0 -> 5
        add(0,0,0,1,0,2'b00, 4,0,0);
        add(0,0,0,1,1,2'b00, 5,0,0);
        add(0,0,0,1,0,2'b00, 4,0,0);                       // dir flip at 5 steps down
        add(0,0,0,1,1,2'b00, 5,0,0);
        add(0,0,0,1,1,2'b00, 0,1,0);                       // dir=1 at 5 wraps
        add(0,0,0,0,1,2'b00, 0,0,0);                       // idle holds
        add(0,1,3,0,1,2'b01, 3,0,0);                       // saturate
        add(0,0,0,1,1,2'b01, 4,0,0);
        add(0,0,0,1,1,2'b01, 5,0,0);
        for (int i = 0; i < 4; i++) add(0,0,0,1,1,2'b01, 5,1,0);
        add(0,0,0,0,1,2'b01, 5,0,0);
        add(0,0,0,1,0,2'b01, 4,0,0);
        add(0,1,0,0,0,2'b01, 0,0,0);
        add(0,0,0,1,0,2'b01, 0,1,0);                       // saturate at 0
        add(0,1,2,0,0,2'b10, 2,0,0);                       // one-shot down
        add(0,0,0,1,0,2'b10, 1,0,0);
        add(0,0,0,1,0,2'b10, 0,0,0);
        add(0,0,0,1,0,2'b10, 0,1,1);
        add(0,0,0,1,0,2'b10, 0,0,1);
        add(0,0,0,1,1,2'b00, 0,0,1);                       // done blocks enable in any mode
        add(0,0,0,1,0,2'b01, 0,0,1);
        add(0,1,4,1,0,2'b10, 4,0,0);                       // load clears done, no step
        add(0,0,0,1,0,2'b10, 3,0,0);
        add(0,0,0,1,0,2'b10, 2,0,0);
        add(0,1,4,0,1,2'b10, 4,0,0);                       // one-shot up
        add(0,0,0,1,1,2'b10, 5,0,0);
        add(0,0,0,1,1,2'b10, 5,1,1);
        add(0,0,0,1,1,2'b10, 5,0,1);
        add(0,1,7,0,1,2'b00, 5,0,0);                       // clamp
        add(0,1,6,1,1,2'b00, 5,0,0);
        add(0,1,2,1,1,2'b00, 2,0,0);
        add(0,1,5,0,1,2'b11, 5,0,0);                       // reserved mode wraps
        add(0,0,0,1,1,2'b11, 0,1,0);
        add(0,0,0,1,0,2'b11, 5,1,0);
        add(0,1,4,0,1,2'b10, 4,0,0);
        add(0,0,0,1,1,2'b10, 5,0,0);
        add(0,0,0,1,1,2'b10, 5,1,1);
        add(1,1,3,1,1,2'b10, 0,0,0);                       // rst beats load+enable with done set
        add(0,0,0,1,1,2'b00, 1,0,0);
        add(0,0,0,1,1,2'b00, 2,0,0);
        add(0,0,0,1,1,2'b00, 3,0,0);
        add(1,1,4,1,1,2'b00, 0,0,0);                       // rst mid-count

        foreach (tbl[i])
            drive(tbl[i].r, tbl[i].l, tbl[i].lv, tbl[i].e, tbl[i].d, tbl[i].m,
                  tbl[i].c, tbl[i].t, tbl[i].dn, $sformatf("vec%0d", i));

        // Load clamp sweep over every representable value
        for (int v = 0; v < 8; v++)
            drive(1'b0, 1'b1, W'(v), 1'b1, 1'b1, 2'b00, W'((v > MV) ? MV : v), 1'b0, 1'b0,
                  $sformatf("clamp%0d", v));

        // Long wrap runs in both directions against a modulo model
        drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 2'b00, '0, 1'b0, 1'b0, "rst_up");
        for (int i = 0; i < 20; i++) begin
            int k;
            k = (i + 1) % (MV + 1);
            drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 2'b00, W'(k), (k == 0), 1'b0,
                  $sformatf("wrap_up%0d", i));
        end
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 2'b00, '0, 1'b0, 1'b0, "rst_dn");
        for (int i = 0; i < 13; i++) begin
            int k;
            k = (MV + 1 - ((i + 1) % (MV + 1))) % (MV + 1);
            drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 2'b00, W'(k), (k == MV), 1'b0,
                  $sformatf("wrap_dn%0d", i));
        end

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
